// File: rtl/mac_pkg.sv
// mac_pkg: shared definitions for the MAC stream engine.
//   mac_state_t    : engine FSM states (IDLE, ACCUM, DRAIN, RESULT)
//   CONV_LEN       : job length used by the convolution windows
//   FC_LEN         : job length used by the fully-connected rows
//   pp_result_t    : post-processing result {val, ovf}
//   post_process() : round, shift, optional ReLU and saturate of an accumulator
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DRAIN  = 2'd2,
    RESULT = 2'd3
  } mac_state_t;

  localparam int CONV_LEN = 25;
  localparam int FC_LEN   = 192;

  // Post-processing runs on a wide signed value so the rounding add and
  // the saturation bounds can never wrap, whatever ACC_W/OUT_W are chosen.
  localparam int PP_W = 128;

  // ovf sits in the LSB so a caller can take {val[OUT_W-1:0], ovf} with a
  // single size cast of OUT_W+1 bits.
  typedef struct packed {
    logic signed [PP_W-1:0] val;
    logic                   ovf;
  } pp_result_t;

  function automatic pp_result_t post_process(
    input logic signed [PP_W-1:0] acc,
    input int                     shift,
    input logic                   relu,
    input int                     out_w
  );
    logic signed [PP_W-1:0] one;
    logic signed [PP_W-1:0] v;
    logic signed [PP_W-1:0] hi;
    logic signed [PP_W-1:0] lo;
    pp_result_t             r;
    one = PP_W'(1);
    v   = acc;
    if (shift != 0) v = v + (one <<< (shift - 1));
    v = v >>> shift;
    if (relu && v[PP_W-1]) v = '0;
    hi    = (one <<< (out_w - 1)) - one;
    lo    = -hi - one;
    r.val = v;
    r.ovf = 1'b0;
    if (v > hi) begin
      r.val = hi;
      r.ovf = 1'b1;
    end else if (v < lo) begin
      r.val = lo;
      r.ovf = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_stream_engine_dot.sv
// mac_lane_dot: LANES signed multipliers feeding a balanced adder tree,
// with a single enabled output register.
//   clk, reset : clock, asynchronous active-high reset (clears sum)
//   en         : load the tree result into sum
//   a, b       : packed signed operands, lane i at [i*DATA_W +: DATA_W]
//   sum        : registered signed sum of the lane products
module mac_lane_dot #(
  parameter int DATA_W = 16,
  parameter int LANES  = 1,
  parameter int SUM_W  = 2 * DATA_W + $clog2(LANES)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic [LANES*DATA_W-1:0]   a,
  input  logic [LANES*DATA_W-1:0]   b,
  output logic signed [SUM_W-1:0]   sum
);

  localparam int LVLS   = $clog2(LANES);
  localparam int PADDED = 1 << LVLS;

  // Level 0 holds the products (padded to a power of two with zeros);
  // each following level halves the node count.
  for (genvar l = 0; l <= LVLS; l++) begin : g_lvl
    localparam int N = PADDED >> l;
    logic signed [SUM_W-1:0] s [N];
    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < N; i++) begin : g_lane
        if (i < LANES) begin : g_mul
          logic signed [DATA_W-1:0]   pa;
          logic signed [DATA_W-1:0]   pb;
          logic signed [2*DATA_W-1:0] p;
          assign pa   = a[i*DATA_W +: DATA_W];
          assign pb   = b[i*DATA_W +: DATA_W];
          assign p    = pa * pb;
          assign s[i] = SUM_W'(p);
        end else begin : g_pad
          assign s[i] = '0;
        end
      end
    end else begin : g_add
      for (genvar i = 0; i < N; i++) begin : g_node
        assign s[i] = g_lvl[l-1].s[2*i] + g_lvl[l-1].s[2*i+1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum <= '0;
    end else if (en) begin
      sum <= g_lvl[LVLS].s[0];
    end
  end

endmodule

// File: rtl/mac_stream_engine.sv
// mac_stream_engine: handshaked multiply-accumulate engine with a per-job
// length, bias preload, rounding shift, optional ReLU and saturation.
//   clk, reset        : clock, asynchronous active-high reset
//   start             : job request, sampled only in IDLE
//   len, bias, shift,
//   relu_en           : job parameters captured with start
//   in_valid/in_ready : operand beat handshake (a, b packed per lane)
//   out_valid/out_ready: result handshake (out, ovf)
//   busy              : high whenever the FSM is not in IDLE
//   dbg_state         : current FSM state for observation
//
// Handshake rule (both ports): a transfer happens on a rising clk edge
// where valid and ready are both high; the producer holds its data stable
// while valid is high and ready is low. in_ready is high exactly in ACCUM,
// out_valid exactly in RESULT, so both depend only on registered state.
//
// ACC_W must be at least 2*DATA_W + clog2(LANES) + LEN_W.
module mac_stream_engine
  import mac_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int LANES  = 1,
  parameter int ACC_W  = 40,
  parameter int OUT_W  = 32,
  parameter int LEN_W  = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [LEN_W-1:0]            len,
  input  logic signed [ACC_W-1:0]     bias,
  input  logic [$clog2(ACC_W)-1:0]    shift,
  input  logic                        relu_en,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_W-1:0]     a,
  input  logic [LANES*DATA_W-1:0]     b,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_W-1:0]     out,
  output logic                        ovf,
  output logic                        busy,
  output mac_state_t                  dbg_state
);

  localparam int SUM_W = 2 * DATA_W + $clog2(LANES);
  localparam int SH_W  = $clog2(ACC_W);

  mac_state_t               state;
  logic [LEN_W-1:0]         len_q;
  logic [SH_W-1:0]          shift_q;
  logic                     relu_q;
  logic [LEN_W-1:0]         cnt;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_final;
  logic signed [SUM_W-1:0]  prod;
  logic                     prod_vld;
  logic                     beat;

  assign beat      = in_valid && (state == ACCUM);
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == RESULT);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  mac_lane_dot #(
    .DATA_W (DATA_W),
    .LANES  (LANES),
    .SUM_W  (SUM_W)
  ) u_dot (
    .clk   (clk),
    .reset (reset),
    .en    (beat),
    .a     (a),
    .b     (b),
    .sum   (prod)
  );

  // The product register lags the beat by one edge; prod_vld marks that
  // it still has to be folded into acc.
  always_comb begin
    acc_final = acc;
    if (prod_vld) acc_final = acc + ACC_W'(prod);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      len_q    <= '0;
      shift_q  <= '0;
      relu_q   <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      prod_vld <= 1'b0;
      out      <= '0;
      ovf      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            len_q    <= len;
            shift_q  <= shift;
            relu_q   <= relu_en;
            acc      <= bias;
            cnt      <= '0;
            prod_vld <= 1'b0;
            state    <= (len == '0) ? DRAIN : ACCUM;
          end
        end
        ACCUM: begin
          acc      <= acc_final;
          prod_vld <= beat;
          if (beat) begin
            cnt <= cnt + 1'b1;
            if (cnt == len_q - 1'b1) state <= DRAIN;
          end
        end
        DRAIN: begin
          // The last product is folded in and post-processed in this one
          // cycle so the result is registered on the DRAIN->RESULT edge.
          acc          <= acc_final;
          prod_vld     <= 1'b0;
          {out, ovf}   <= (OUT_W + 1)'(post_process(PP_W'(acc_final), int'(shift_q), relu_q, OUT_W));
          state        <= RESULT;
        end
        RESULT: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_stream_engine.sv
module tb_mac_stream_engine;
  import mac_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // LANES=1 instance
  logic        u1_reset, u1_start, u1_relu_en, u1_in_valid, u1_in_ready;
  logic [7:0]  u1_len;
  logic [39:0] u1_bias;
  logic [5:0]  u1_shift;
  logic [15:0] u1_a, u1_b;
  logic        u1_out_valid, u1_out_ready, u1_ovf, u1_busy;
  logic [31:0] u1_out;
  mac_state_t  u1_dbg;

  // LANES=4 instance
  logic        u4_reset, u4_start, u4_relu_en, u4_in_valid, u4_in_ready;
  logic [7:0]  u4_len;
  logic [39:0] u4_bias;
  logic [5:0]  u4_shift;
  logic [63:0] u4_a, u4_b;
  logic        u4_out_valid, u4_out_ready, u4_ovf, u4_busy;
  logic [31:0] u4_out;
  mac_state_t  u4_dbg;

  mac_stream_engine #(.DATA_W(16), .LANES(1), .ACC_W(40), .OUT_W(32), .LEN_W(8)) dut1 (
    .clk(clk), .reset(u1_reset), .start(u1_start), .len(u1_len), .bias(u1_bias),
    .shift(u1_shift), .relu_en(u1_relu_en), .in_valid(u1_in_valid), .in_ready(u1_in_ready),
    .a(u1_a), .b(u1_b), .out_valid(u1_out_valid), .out_ready(u1_out_ready), .out(u1_out),
    .ovf(u1_ovf), .busy(u1_busy), .dbg_state(u1_dbg)
  );

  mac_stream_engine #(.DATA_W(16), .LANES(4), .ACC_W(40), .OUT_W(32), .LEN_W(8)) dut4 (
    .clk(clk), .reset(u4_reset), .start(u4_start), .len(u4_len), .bias(u4_bias),
    .shift(u4_shift), .relu_en(u4_relu_en), .in_valid(u4_in_valid), .in_ready(u4_in_ready),
    .a(u4_a), .b(u4_b), .out_valid(u4_out_valid), .out_ready(u4_out_ready), .out(u4_out),
    .ovf(u4_ovf), .busy(u4_busy), .dbg_state(u4_dbg)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [32:0] exp1_q[$];
  logic [32:0] exp4_q[$];
  int bp1 = 0;   // out_ready mode: 0 always ready, 1 random, 2 held low
  int bp4 = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Plain integer arithmetic: dot product plus bias, wrapped to 40 bits,
  // then round / shift / ReLU / clamp to 32-bit signed.
  function automatic logic [32:0] model(input longint bias, input int len,
                                        input logic [63:0] av[$], input logic [63:0] bv[$],
                                        input int lanes, input int sh, input bit relu);
    longint acc, r;
    logic [63:0] ta, tb;
    logic [15:0] x, y;
    logic ovf_m;
    acc = bias;
    for (int k = 0; k < len; k++) begin
      ta = av[k];
      tb = bv[k];
      for (int l = 0; l < lanes; l++) begin
        x = ta[l*16 +: 16];
        y = tb[l*16 +: 16];
        acc += longint'($signed(x)) * longint'($signed(y));
      end
    end
    acc = (acc <<< 24) >>> 24;
    r = acc;
    if (sh > 0) r += (longint'(1) <<< (sh - 1));
    r = r >>> sh;
    if (relu && r < 0) r = 0;
    ovf_m = 1'b0;
    if (r > 64'sd2147483647) begin r = 64'sd2147483647; ovf_m = 1'b1; end
    else if (r < -64'sd2147483648) begin r = -64'sd2147483648; ovf_m = 1'b1; end
    return {ovf_m, r[31:0]};
  endfunction

  // ---------------- output backpressure ----------------
  always @(posedge clk) begin
    #2;
    u1_out_ready = (bp1 == 0) ? 1'b1 : (bp1 == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    u4_out_ready = (bp4 == 0) ? 1'b1 : (bp4 == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  // ---------------- monitors ----------------
  logic [32:0] held1, held4;
  bit stall1 = 0, stall4 = 0;

  always @(negedge clk) begin
    if (u1_out_valid) begin
      if (stall1) check("u1_hold_stable", {u1_ovf, u1_out}, held1);
      if (u1_out_ready) begin
        if (exp1_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL u1_result: got 0x%0h, expected nothing queued", {u1_ovf, u1_out});
        end else check("u1_result", {u1_ovf, u1_out}, exp1_q.pop_front());
        stall1 = 0;
      end else begin
        stall1 = 1;
        held1  = {u1_ovf, u1_out};
      end
    end else stall1 = 0;
  end

  always @(negedge clk) begin
    if (u4_out_valid) begin
      if (stall4) check("u4_hold_stable", {u4_ovf, u4_out}, held4);
      if (u4_out_ready) begin
        if (exp4_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL u4_result: got 0x%0h, expected nothing queued", {u4_ovf, u4_out});
        end else check("u4_result", {u4_ovf, u4_out}, exp4_q.pop_front());
        stall4 = 0;
      end else begin
        stall4 = 1;
        held4  = {u4_ovf, u4_out};
      end
    end else stall4 = 0;
  end

  // ---------------- driver helpers ----------------
  task automatic drive_start(input bit sel4, input bit s, input int len, input longint bias,
                             input int sh, input bit relu);
    if (sel4) begin
      u4_start = s; u4_len = 8'(len); u4_bias = bias[39:0]; u4_shift = 6'(sh); u4_relu_en = relu;
    end else begin
      u1_start = s; u1_len = 8'(len); u1_bias = bias[39:0]; u1_shift = 6'(sh); u1_relu_en = relu;
    end
  endtask

  task automatic drive_beat(input bit sel4, input bit v, input logic [63:0] x, input logic [63:0] y);
    if (sel4) begin u4_in_valid = v; u4_a = x; u4_b = y; end
    else begin u1_in_valid = v; u1_a = x[15:0]; u1_b = y[15:0]; end
  endtask

  function automatic logic rd_in_ready(input bit sel4);  return sel4 ? u4_in_ready  : u1_in_ready;  endfunction
  function automatic logic rd_out_valid(input bit sel4); return sel4 ? u4_out_valid : u1_out_valid; endfunction
  function automatic logic rd_busy(input bit sel4);      return sel4 ? u4_busy      : u1_busy;      endfunction

  task automatic check_reset_outputs(input bit sel4, input string tag);
    check({tag, "_in_ready"},  rd_in_ready(sel4), 0);
    check({tag, "_out_valid"}, rd_out_valid(sel4), 0);
    check({tag, "_busy"},      rd_busy(sel4), 0);
    check({tag, "_out"},       sel4 ? u4_out : u1_out, 0);
    check({tag, "_ovf"},       sel4 ? u4_ovf : u1_ovf, 0);
    check({tag, "_state"},     sel4 ? u4_dbg : u1_dbg, IDLE);
  endtask

  // Runs one job starting at a negedge with the DUT idle; returns at a
  // negedge with the DUT idle again. abort_at >= 0 resets the DUT while
  // that beat is being presented. hold > 0 expects out_ready held low.
  task automatic run_job(input bit sel4, input int len, input longint bias, input int sh,
                         input bit relu, input int stall_pct,
                         input logic [63:0] av[$], input logic [63:0] bv[$],
                         input bit has_exp, input logic [32:0] exp_v,
                         input int abort_at, input int hold);
    int idx, guard;
    bit v, accepted, aborted;
    if (abort_at < 0) begin
      if (has_exp) begin
        if (sel4) exp4_q.push_back(exp_v); else exp1_q.push_back(exp_v);
      end else begin
        if (sel4) exp4_q.push_back(model(bias, len, av, bv, 4, sh, relu));
        else      exp1_q.push_back(model(bias, len, av, bv, 1, sh, relu));
      end
    end
    drive_start(sel4, 1'b1, len, bias, sh, relu);
    @(negedge clk);
    drive_start(sel4, 1'b0, 0, 0, 0, 1'b0);
    idx = 0; guard = 0; aborted = 0;
    while (idx < len) begin
      if (guard > 4000) begin
        checks++; errors++;
        $display("FAIL beat_timeout: got %0d beats accepted, expected %0d", idx, len);
        break;
      end
      if (idx == abort_at) begin
        if (sel4) u4_reset = 1'b1; else u1_reset = 1'b1;
        drive_beat(sel4, 1'b0, 64'd0, 64'd0);
        @(posedge clk); #1;
        check_reset_outputs(sel4, "midjob_reset");
        @(negedge clk);
        if (sel4) u4_reset = 1'b0; else u1_reset = 1'b0;
        aborted = 1;
        break;
      end
      v = ($urandom_range(0, 99) >= stall_pct);
      drive_beat(sel4, v, av[idx], bv[idx]);
      check("in_ready_accum", rd_in_ready(sel4), 1);
      accepted = v && rd_in_ready(sel4);
      @(negedge clk);
      if (accepted) idx++;
      guard++;
    end
    if (aborted) return;
    if (stall_pct == 0 && len > 0) check("full_throughput_cycles", guard, len);
    drive_beat(sel4, 1'b0, 64'd0, 64'd0);
    // One edge after the final accept (or start edge for len 0): DRAIN.
    check("out_valid_early", rd_out_valid(sel4), 0);
    check("in_ready_after_last", rd_in_ready(sel4), 0);
    check("busy_in_job", rd_busy(sel4), 1);
    @(negedge clk);
    check("out_valid_latency", rd_out_valid(sel4), 1);
    for (int h = 0; h < hold; h++) begin
      check("stall_out_valid", rd_out_valid(sel4), 1);
      check("stall_in_ready", rd_in_ready(sel4), 0);
      if (h == 1) drive_start(sel4, 1'b1, 3, 64'd7, 0, 1'b0);
      if (h == 2) drive_start(sel4, 1'b0, 0, 0, 0, 1'b0);
      @(negedge clk);
    end
    if (hold > 0) begin
      if (sel4) bp4 = 0; else bp1 = 0;
    end
    guard = 0;
    while (rd_busy(sel4) && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 4000) begin
      checks++; errors++;
      $display("FAIL result_timeout: got busy=1 after %0d cycles, expected idle", guard);
    end
    if (hold > 0) begin
      check("start_ignored_busy", rd_busy(sel4), 0);
      @(negedge clk);
      check("start_ignored_busy2", rd_busy(sel4), 0);
    end
  endtask

  task automatic fill(input int n, input logic [63:0] val, output logic [63:0] q[$]);
    q = {};
    for (int k = 0; k < n; k++) q.push_back(val);
  endtask

  task automatic rand_job(input bit sel4);
    logic [63:0] av[$], bv[$], r64, m;
    logic [39:0] b40;
    int len, sh, mode;
    longint bias;
    bit relu;
    len  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : $urandom_range(1, 40);
    mode = $urandom_range(0, 1);
    m    = mode ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h00FF_00FF_00FF_00FF;
    av = {}; bv = {};
    for (int k = 0; k < len; k++) begin
      r64 = {$urandom, $urandom}; av.push_back(r64 & m);
      r64 = {$urandom, $urandom}; bv.push_back(r64 & m);
    end
    r64 = {$urandom, $urandom};
    b40 = r64[39:0];
    if ($urandom_range(0, 2) == 0) bias = longint'($signed(b40));
    else bias = longint'($urandom_range(0, 2000)) - 64'sd1000;
    sh   = $urandom_range(0, 24);
    relu = 1'($urandom_range(0, 1));
    if (sel4) bp4 = $urandom_range(0, 1); else bp1 = $urandom_range(0, 1);
    run_job(sel4, len, bias, sh, relu, $urandom_range(0, 50), av, bv, 1'b0, 33'd0, -1, 0);
    if (sel4) bp4 = 0; else bp1 = 0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3000000;
    $display("FAIL watchdog: got no completion, expected finish before %0t", $time);
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] av[$], bv[$];
    u1_reset = 1'b1; u4_reset = 1'b1;
    u1_out_ready = 1'b1; u4_out_ready = 1'b1;
    drive_start(1'b0, 1'b0, 0, 0, 0, 1'b0);
    drive_start(1'b1, 1'b0, 0, 0, 0, 1'b0);
    drive_beat(1'b0, 1'b0, 64'd0, 64'd0);
    drive_beat(1'b1, 1'b0, 64'd0, 64'd0);
    repeat (3) @(negedge clk);
    check_reset_outputs(1'b0, "u1_reset");
    check_reset_outputs(1'b1, "u4_reset");
    u1_reset = 1'b0; u4_reset = 1'b0;
    @(negedge clk);

    // 25 beats of 2*3 -> 150
    fill(25, 64'd2, av); fill(25, 64'd3, bv);
    run_job(1'b0, 25, 0, 0, 1'b0, 0, av, bv, 1'b1, {1'b0, 32'd150}, -1, 0);

    // 192 beats of -1*100 with random input stalls
    fill(192, 64'h0000_0000_0000_FFFF, av); fill(192, 64'd100, bv);
    run_job(1'b0, 192, 0, 0, 1'b0, 40, av, bv, 1'b1, {1'b0, 32'hFFFF_B500}, -1, 0);
    run_job(1'b0, 192, 0, 0, 1'b1, 40, av, bv, 1'b1, {1'b0, 32'd0}, -1, 0);

    // rounding with len 0
    av = {}; bv = {};
    run_job(1'b0, 0, 5, 1, 1'b0, 0, av, bv, 1'b1, {1'b0, 32'd3}, -1, 0);
    run_job(1'b0, 0, -5, 1, 1'b0, 0, av, bv, 1'b1, {1'b0, 32'hFFFF_FFFE}, -1, 0);

    // saturation
    run_job(1'b0, 0, 64'sd34359738368, 0, 1'b0, 0, av, bv, 1'b1, {1'b1, 32'h7FFF_FFFF}, -1, 0);
    run_job(1'b0, 0, -64'sd34359738368, 0, 1'b0, 0, av, bv, 1'b1, {1'b1, 32'h8000_0000}, -1, 0);

    // reset during beat 10 of a 25-beat job, then a clean rerun
    fill(25, 64'd2, av); fill(25, 64'd3, bv);
    run_job(1'b0, 25, 0, 0, 1'b0, 0, av, bv, 1'b0, 33'd0, 9, 0);
    run_job(1'b0, 25, 0, 0, 1'b0, 0, av, bv, 1'b1, {1'b0, 32'd150}, -1, 0);

    // LANES=4: (1,2,3,4).(1,1,1,1) + (-1,-1,-1,-1).(2,2,2,2) = 2, with output stall
    av = {64'h0004_0003_0002_0001, 64'hFFFF_FFFF_FFFF_FFFF};
    bv = {64'h0001_0001_0001_0001, 64'h0002_0002_0002_0002};
    bp4 = 2;
    run_job(1'b1, 2, 0, 0, 1'b0, 0, av, bv, 1'b1, {1'b0, 32'd2}, -1, 5);

    for (int j = 0; j < 15; j++) rand_job(1'b0);
    for (int j = 0; j < 15; j++) rand_job(1'b1);

    repeat (5) @(negedge clk);
    check("u1_queue_drained", exp1_q.size(), 0);
    check("u4_queue_drained", exp4_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
